// File: rtl/uv_led_pkg.sv
// Shared constants and state encoding for the UV LED DAC driver.
package uv_led_pkg;

  localparam int unsigned I_MAX     = 167772;  // 20 mA in Q9.23 amps
  localparam int unsigned DAC_SCALE = 25599;
  localparam logic [7:0]  DAC_CMD   = 8'h30;   // write-and-update

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StHold,
    StGap
  } state_e;

endpackage

// File: rtl/uv_led_i2code.sv
// Clamps a Q9.23 current command and scales it to a 16-bit DAC code.
// The code register loads during the LOAD cycle of the frame FSM.
module uv_led_i2code #(
  parameter int unsigned DAC_SCALE = uv_led_pkg::DAC_SCALE,
  parameter int unsigned I_MAX     = uv_led_pkg::I_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] i_current,
  output logic [15:0] code
);

  logic [31:0] clamped;
  logic [47:0] product;
  logic [31:0] scaled;

  // Bit 31 set means the PID loop asked for negative current.
  always_comb begin
    if (i_current[31]) begin
      clamped = '0;
    end else if (i_current > I_MAX) begin
      clamped = I_MAX;
    end else begin
      clamped = i_current;
    end
  end

  assign product = 48'(clamped) * 48'(DAC_SCALE);
  assign scaled  = 32'(product >> 16);

  always_ff @(posedge clk) begin
    if (rst) begin
      code <= '0;
    end else if (load) begin
      code <= (scaled > 32'h0000_FFFF) ? 16'hFFFF : scaled[15:0];
    end
  end

endmodule

// File: rtl/uv_led_dac_driver.sv
// Periodically samples the LED current command and writes it to an SPI DAC
// as a 24-bit write-and-update frame (CPOL=0, CPHA=0, MSB first).
module uv_led_dac_driver #(
  parameter int unsigned UPDATE_DIV = 1000,
  parameter int unsigned SCLK_DIV   = 4,
  parameter int unsigned DAC_SCALE  = uv_led_pkg::DAC_SCALE,
  parameter int unsigned I_MAX      = uv_led_pkg::I_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] i_current,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic        busy,
  output logic [15:0] dac_code,
  output logic        frame_done
);
  import uv_led_pkg::*;

  localparam int unsigned TickW = $clog2(UPDATE_DIV);
  localparam int unsigned DivW  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [TickW-1:0] tick_cnt_q;
  logic             tick;
  state_e           state_q;
  logic [31:0]      cur_q;
  logic [DivW-1:0]  div_q;
  logic             div_end;
  logic [4:0]       bit_q;
  logic [4:0]       bit_nxt;
  logic [15:0]      code;
  logic [23:0]      frame;

  assign tick    = (tick_cnt_q == TickW'(UPDATE_DIV - 1));
  assign div_end = (div_q == DivW'(SCLK_DIV - 1));
  assign bit_nxt = bit_q - 5'd1;
  assign frame   = {DAC_CMD, code};

  always_ff @(posedge clk) begin
    assert (SCLK_DIV >= 2 && UPDATE_DIV >= 50 * SCLK_DIV + 2)
      else $error("uv_led_dac_driver: UPDATE_DIV must be >= 50*SCLK_DIV+2, SCLK_DIV >= 2");
  end

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TickW'(1);
    end
  end

  uv_led_i2code #(
    .DAC_SCALE (DAC_SCALE),
    .I_MAX     (I_MAX)
  ) u_i2code (
    .clk       (clk),
    .rst       (rst),
    .load      (state_q == StLoad),
    .i_current (cur_q),
    .code      (code)
  );

  // The LOAD cycle counts as the first cycle of the first SCLK low phase, so
  // chip select is low for exactly 49 half-periods.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_mosi   <= 1'b0;
      busy       <= 1'b0;
      dac_code   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tick && enable) begin
            state_q  <= StLoad;
            cur_q    <= i_current;
            div_q    <= '0;
            bit_q    <= 5'd23;
            dac_cs_n <= 1'b0;
            dac_mosi <= DAC_CMD[7];
            busy     <= 1'b1;
          end
        end
        StLoad: begin
          state_q <= StShift;
          div_q   <= div_q + DivW'(1);
        end
        StShift: begin
          if (div_end) begin
            div_q    <= '0;
            dac_sclk <= ~dac_sclk;
            if (dac_sclk) begin
              if (bit_q == 5'd0) begin
                state_q  <= StHold;
                dac_mosi <= 1'b0;
              end else begin
                bit_q    <= bit_nxt;
                dac_mosi <= frame[bit_nxt];
              end
            end
          end else begin
            div_q <= div_q + DivW'(1);
          end
        end
        StHold: begin
          if (div_end) begin
            div_q    <= '0;
            dac_cs_n <= 1'b1;
            state_q  <= StGap;
          end else begin
            div_q <= div_q + DivW'(1);
          end
        end
        StGap: begin
          if (div_end) begin
            div_q      <= '0;
            state_q    <= StIdle;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            dac_code   <= code;
          end else begin
            div_q <= div_q + DivW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uv_led_dac_driver.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge monitor
// reassembles the SPI traffic and compares it against them.
module tb_uv_led_dac_driver;

  localparam int unsigned UpdateDiv = 1000;
  localparam int unsigned SclkDiv   = 4;
  localparam longint unsigned ModelImax  = 167772;
  localparam longint unsigned ModelScale = 25599;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] i_current;
  logic        dac_cs_n;
  logic        dac_sclk;
  logic        dac_mosi;
  logic        busy;
  logic [15:0] dac_code;
  logic        frame_done;

  uv_led_dac_driver #(
    .UPDATE_DIV (UpdateDiv),
    .SCLK_DIV   (SclkDiv)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .i_current  (i_current),
    .dac_cs_n   (dac_cs_n),
    .dac_sclk   (dac_sclk),
    .dac_mosi   (dac_mosi),
    .busy       (busy),
    .dac_code   (dac_code),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_exp    = 0;
  int n_done   = 0;
  int cyc      = 0;
  logic [23:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Reference model: clamp, scale, saturate, prepend the command byte.
  function automatic logic [23:0] model_frame(input logic [31:0] i);
    longint unsigned amps;
    longint unsigned code;
    if (i[31]) amps = 0;
    else if (longint'(i) > ModelImax) amps = ModelImax;
    else amps = longint'(i);
    code = (amps * ModelScale) / 65536;
    if (code > 65535) code = 65535;
    return {8'h30, code[15:0]};
  endfunction

  // Monitor state
  logic        prev_cs_n = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_mosi = 1'b0;
  bit          in_frame  = 0;
  bit          wait_done = 0;
  bit          have_last = 0;
  bit          mosi_bad  = 0;
  int          low_cnt, rise_cnt, gap_cnt, last_start;
  logic [23:0] shreg, cur_exp;

  always @(negedge clk) begin
    if (rst) begin
      in_frame  = 0;
      wait_done = 0;
      have_last = 0;
    end else begin
      if (frame_done) begin
        chk("done_expected", {31'd0, wait_done}, 32'd1);
        if (wait_done) begin
          chk("done_gap_cycles", gap_cnt + 1, SclkDiv);
          chk("dac_code", dac_code, {16'd0, cur_exp[15:0]});
          chk("busy_at_done", busy, 32'd0);
          n_done++;
          wait_done = 0;
        end
      end else if (wait_done) begin
        gap_cnt++;
        if (gap_cnt > int'(SclkDiv) + 3) begin
          chk("done_timeout", gap_cnt, SclkDiv);
          wait_done = 0;
        end
      end

      if (!in_frame && prev_cs_n && !dac_cs_n) begin
        chk("frame_was_expected", exp_q.size() != 0, 32'd1);
        cur_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 24'h0;
        chk("busy_at_start", busy, 32'd1);
        chk("mosi_bit23_at_start", dac_mosi, {31'd0, cur_exp[23]});
        if (have_last) chk("start_spacing", (cyc - last_start) % UpdateDiv, 32'd0);
        have_last  = 1;
        last_start = cyc;
        in_frame   = 1;
        low_cnt    = 1;
        rise_cnt   = 0;
        mosi_bad   = 0;
        shreg      = '0;
      end else if (in_frame && !dac_cs_n) begin
        low_cnt++;
        if (!prev_sclk && dac_sclk) begin
          rise_cnt++;
          shreg = {shreg[22:0], dac_mosi};
          if (dac_mosi !== prev_mosi) mosi_bad = 1;
        end
        if (low_cnt > 400) begin
          chk("cs_low_timeout", low_cnt, 49 * SclkDiv);
          in_frame = 0;
        end
      end else if (in_frame && dac_cs_n) begin
        in_frame = 0;
        chk("cs_low_cycles", low_cnt, 49 * SclkDiv);
        chk("sclk_rises", rise_cnt, 32'd24);
        chk("mosi_stable_on_rise", {31'd0, mosi_bad}, 32'd0);
        chk("frame_bits", {8'd0, shreg}, {8'd0, cur_exp});
        chk("sclk_low_after_cs", dac_sclk, 32'd0);
        wait_done = 1;
        gap_cnt   = 0;
      end
    end
    prev_cs_n = dac_cs_n;
    prev_sclk = dac_sclk;
    prev_mosi = dac_mosi;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cs_n"}, dac_cs_n, 32'd1);
    chk({tag, "_sclk"}, dac_sclk, 32'd0);
    chk({tag, "_mosi"}, dac_mosi, 32'd0);
    chk({tag, "_busy"}, busy, 32'd0);
    chk({tag, "_code"}, dac_code, 32'd0);
    chk({tag, "_done"}, frame_done, 32'd0);
  endtask

  // One 1000-cycle period starting at tick-counter phase 0: scramble the
  // inputs mid-frame, then set the real command well before the next tick.
  task automatic run_period(input logic [31:0] val, input bit en);
    wait_cycles(100);
    i_current = $urandom;
    enable    = 1'b0;
    wait_cycles(400);
    i_current = val;
    enable    = en;
    if (en) begin
      exp_q.push_back(model_frame(val));
      n_exp++;
    end
    wait_cycles(500);
  endtask

  task automatic abort_period(input logic [31:0] val);
    int waited = 0;
    wait_cycles(500);
    i_current = val;
    enable    = 1'b1;
    exp_q.push_back(model_frame(val));
    while (!busy && waited < 700) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("abort_frame_started", busy, 32'd1);
    wait_cycles(50);
    rst    = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
  endtask

  logic [31:0] dir_val[7] = '{32'd167772, 32'd83886, 32'h8000_0000, 32'hFFFF_FFF0,
                              32'h0100_0000, 32'd50000, 32'd12345};
  bit          dir_en[7]  = '{1, 1, 1, 1, 1, 0, 0};

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    i_current = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int k = 0; k < 7; k++) run_period(dir_val[k], dir_en[k]);

    abort_period(32'd100000);
    run_period(32'd83886, 1'b1);

    for (int k = 0; k < 6; k++) begin
      logic [31:0] v;
      v = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 200000));
      run_period(v, $urandom_range(0, 3) != 0);
    end

    enable = 1'b0;
    wait_cycles(600);
    chk("frames_completed", n_done, n_exp);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
